// File: rtl/i2s_master.sv
// I2S master transmitter: divides clk_i into BCLK/LRCLK and serialises one sample into both slots of every frame.
// Define I2S_MASTER_LEFT_JUSTIFIED_EN for left-justified framing; otherwise standard I2S with a one-BCLK delay after WS.
module i2s_master #(
  parameter int BCLK_HALF_DIV = 7,
  parameter int SAMPLE_W      = 24,
  parameter int SLOT_W        = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] audio_data_i,
  output logic [SAMPLE_W-1:0] wave_o,
  output logic                audio_data_o,
  output logic                audio_lrclk_o,
  output logic                audio_bclk_o
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int B_W        = $clog2(FRAME_BITS);
  localparam int PRE_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BCLK_HALF_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(FRAME_BITS - 1);
  localparam logic [B_W-1:0]   B_SLOT   = B_W'(SLOT_W);

  logic [PRE_W-1:0]    pre_r;
  logic                bclk_r;
  logic                lrclk_r;
  logic                data_r;
  logic [B_W-1:0]      b_r;
  logic [SAMPLE_W-1:0] sample_r;

  logic                tc_s;
  logic                fall_s;
  logic [B_W-1:0]      b_next_s;
  logic                lr_next_s;
  logic [B_W-1:0]      s_next_s;
  logic [SAMPLE_W-1:0] sample_next_s;
  logic                data_next_s;

  // SD value for position s within a slot; positions outside the sample window are padding zeros.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] smp, input logic [B_W-1:0] s);
    logic bit_v;
    bit_v = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
`ifdef I2S_MASTER_LEFT_JUSTIFIED_EN
      bit_v = bit_v | (smp[i] & (s == B_W'(SAMPLE_W - 1 - i)));
`else
      bit_v = bit_v | (smp[i] & (s == B_W'(SAMPLE_W - i)));
`endif
    end
    return bit_v;
  endfunction

  // Next-state values applied on the BCLK falling edge.
  always_comb begin
    tc_s   = (pre_r == PRE_LAST);
    fall_s = tc_s & bclk_r;
    if (b_r == B_LAST) begin
      b_next_s = '0;
    end else begin
      b_next_s = b_r + B_W'(1);
    end
    lr_next_s = (b_next_s >= B_SLOT);
    if (lr_next_s) begin
      s_next_s = b_next_s - B_SLOT;
    end else begin
      s_next_s = b_next_s;
    end
    // The new sample is taken at the LRCLK fall so the first bit of the frame already uses it.
    if (b_next_s == '0) begin
      sample_next_s = audio_data_i;
    end else begin
      sample_next_s = sample_r;
    end
    data_next_s = slot_bit(sample_next_s, s_next_s);
  end

  // Prescaler, BCLK toggle and falling-edge bit/frame sequencing.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      pre_r    <= '0;
      bclk_r   <= 1'b0;
      lrclk_r  <= 1'b1;
      data_r   <= 1'b0;
      b_r      <= B_LAST;
      sample_r <= '0;
    end else begin
      if (tc_s) begin
        pre_r  <= '0;
        bclk_r <= ~bclk_r;
      end else begin
        pre_r  <= pre_r + PRE_W'(1);
      end
      if (fall_s) begin
        b_r      <= b_next_s;
        lrclk_r  <= lr_next_s;
        data_r   <= data_next_s;
        sample_r <= sample_next_s;
      end
    end
  end

  assign wave_o        = sample_r;
  assign audio_data_o  = data_r;
  assign audio_lrclk_o = lrclk_r;
  assign audio_bclk_o  = bclk_r;

endmodule

// File: tb/tb_i2s_master.sv
// Scoreboard bench for i2s_master: stimulus pushes expected slot words, a BCLK-rising monitor deserialises and compares.
`timescale 1ns/1ps
module tb_i2s_master;

  localparam int SAMPLE_W = 24;

  typedef struct packed {
    logic        lr;
    logic [31:0] word;
  } slot_t;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                enable_i = 1'b0;
  logic [SAMPLE_W-1:0] audio_data_i = '0;
  logic [SAMPLE_W-1:0] wave_o;
  logic                audio_data_o;
  logic                audio_lrclk_o;
  logic                audio_bclk_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  slot_t exp_q[$];

  i2s_master dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .audio_data_i (audio_data_i),
    .wave_o       (wave_o),
    .audio_data_o (audio_data_o),
    .audio_lrclk_o(audio_lrclk_o),
    .audio_bclk_o (audio_bclk_o)
  );

  always #12.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_word(input logic [SAMPLE_W-1:0] smp);
`ifdef I2S_MASTER_LEFT_JUSTIFIED_EN
    return {smp, 8'h00};
`else
    return {1'b0, smp, 7'h00};
`endif
  endfunction

  task automatic push_frame(input logic [SAMPLE_W-1:0] smp);
    exp_q.push_back('{lr: 1'b0, word: exp_word(smp)});
    exp_q.push_back('{lr: 1'b1, word: exp_word(smp)});
    checks++;
    if (wave_o !== smp) begin
      errors++;
      $display("FAIL wave_latch: got %06h expected %06h", wave_o, smp);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({audio_bclk_o, audio_lrclk_o, audio_data_o} !== 3'b010 || wave_o !== 24'h000000) begin
      errors++;
      $display("FAIL %s: bclk/lrclk/sd=%b%b%b wave=%06h expected 010 wave=000000",
               name, audio_bclk_o, audio_lrclk_o, audio_data_o, wave_o);
    end
  endtask

  // Drive a sample after pre_wait cycles, wait for the LRCLK fall that latches it, then push its two slots.
  task automatic send_frame(input logic [SAMPLE_W-1:0] smp, input int pre_wait, output int fall_cyc);
    logic prev;
    bit   found;
    repeat (pre_wait) @(posedge clk);
    #2 audio_data_i = smp;
    found = 1'b0;
    fall_cyc = 0;
    prev = audio_lrclk_o;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (prev && !audio_lrclk_o) begin
        found = 1'b1;
        fall_cyc = cyc;
      end
      prev = audio_lrclk_o;
    end
    if (found) begin
      push_frame(smp);
    end else begin
      checks++;
      errors++;
      $display("FAIL lrclk_fall_timeout: no LRCLK fall within 2000 cycles, expected one");
    end
  endtask

  // Monitor: shift SD on each BCLK rise; a new slot starts when LRCLK differs from the previous slot.
  initial begin : monitor
    logic        prev_bclk;
    logic        last_lr;
    logic        in_slot;
    logic        slot_lr;
    logic [31:0] word;
    int          cnt;
    slot_t       e;
    prev_bclk = 1'b0;
    last_lr   = 1'b1;
    in_slot   = 1'b0;
    slot_lr   = 1'b0;
    word      = '0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      if (rst_i || !enable_i) begin
        prev_bclk = 1'b0;
        last_lr   = 1'b1;
        in_slot   = 1'b0;
        cnt       = 0;
      end else begin
        if (audio_bclk_o && !prev_bclk) begin
          if (audio_lrclk_o != last_lr) begin
            in_slot = 1'b1;
            slot_lr = audio_lrclk_o;
            last_lr = audio_lrclk_o;
            cnt     = 0;
            word    = '0;
          end
          if (in_slot) begin
            word = {word[30:0], audio_data_o};
            cnt++;
            if (cnt == 32) begin
              in_slot = 1'b0;
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL slot_unexpected: got lr=%b word=%08h expected no slot", slot_lr, word);
              end else begin
                e = exp_q.pop_front();
                if (e.word !== word || e.lr !== slot_lr) begin
                  errors++;
                  $display("FAIL slot_word: got lr=%b word=%08h expected lr=%b word=%08h",
                           slot_lr, word, e.lr, e.word);
                end
              end
            end
          end
        end
        prev_bclk = audio_bclk_o;
      end
    end
  end

  initial begin : stimulus
    int f1, f2, fx, n, fs;
    // Reset with enable high: reset must win.
    rst_i = 1'b1;
    enable_i = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state");

    @(posedge clk);
    #2 rst_i = 1'b0;
    send_frame(24'h9A5AC3, 0, f1);
    send_frame(24'h9A5AC3, 0, f2);
    checks++;
    if (f2 - f1 != 896) begin
      errors++;
      $display("FAIL frame_period: got %0d cycles expected 896", f2 - f1);
    end
    fs = (f2 - f1 > 0) ? 40000000 / (f2 - f1) : 0;
    checks++;
    if (fs < 42100 || fs > 46100) begin
      errors++;
      $display("FAIL sample_rate: got %0d Hz expected 44100 +/- 2000", fs);
    end

    // Back-to-back samples, then a mid-left-slot input change.
    send_frame(24'h5A5AC2, 0, fx);
    send_frame(24'hDA5AC3, 0, fx);
    send_frame(24'h123456, 0, fx);
    send_frame(24'hABCDEF, 100, fx);

    // Abort via enable mid-frame, then re-enable and time the first LRCLK fall.
    send_frame(24'h111111, 0, fx);
    repeat (200) @(posedge clk);
    #2 enable_i = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 check_idle("enable_off_idle");
    repeat (5) @(posedge clk);
    #2 audio_data_i = 24'h7E0F81;
    enable_i = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 n++;
      if (!audio_lrclk_o) break;
    end
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL reenable_latency: got %0d cycles expected 14", n);
    end
    push_frame(24'h7E0F81);

    for (int k = 0; k < 40; k++) begin
      if (k == 20) begin
        repeat (300) @(posedge clk);
        #2 rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 check_idle("reset_midframe_idle");
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
      end
      send_frame(SAMPLE_W'($urandom), 0, fx);
    end
    send_frame(24'h800001, 0, fx);

    // Let the last frame drain, then stop the clocks before another slot starts.
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    enable_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d slots pending expected 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
